// File: rtl/dbf_chan_param.sv
// Single-channel dynamic-focus beamformer: LUT-driven delay line, apodisation weight,
// round/saturate, with a fixed three-cycle result pipeline behind the accept cycle.
module dbf_chan_param #(
    parameter int INPUT_WD   = 14,
    parameter int APO_WD     = 16,
    parameter int OUT_WD     = 32,
    parameter int DLY_WD     = 8,
    parameter int LUT_AW     = 10,
    parameter int FOCAL_STEP = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tx_en,
    input  logic                       start,
    input  logic signed [INPUT_WD-1:0] ch_in,
    input  logic signed [APO_WD-1:0]   apo_din,
    input  logic                       apo_bypass,
    input  logic [LUT_AW-1:0]          lut_addr,
    input  logic [DLY_WD-1:0]          lut_din,
    input  logic                       lut_we,
    output logic signed [OUT_WD-1:0]   dout,
    output logic                       dout_valid,
    output logic signed [INPUT_WD-1:0] cd_dout,
    output logic                       busy
);

    localparam int unsigned DEPTH     = 2 ** DLY_WD;
    localparam int unsigned LUT_DEPTH = 2 ** LUT_AW;
    localparam int unsigned CW        = DLY_WD + 1;
    localparam int unsigned FSW       = (FOCAL_STEP > 1) ? $clog2(FOCAL_STEP) : 1;
    localparam int unsigned WW        = APO_WD + 1;
    localparam int unsigned PW        = INPUT_WD + APO_WD + 1;
    localparam int unsigned RW        = INPUT_WD + 2;

    localparam logic [CW-1:0]     N_SAT      = CW'(DEPTH);
    localparam logic [FSW-1:0]    STEP_LAST  = FSW'(FOCAL_STEP - 1);
    localparam logic [LUT_AW-1:0] FOCAL_LAST = '1;
    localparam logic signed [WW-1:0] UNITY   = {2'b01, {(APO_WD - 1){1'b0}}};
    localparam logic signed [PW-1:0] RND     = {{(PW - APO_WD + 1){1'b0}}, 1'b1, {(APO_WD - 2){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   lut_wr_ok;

    logic [DLY_WD-1:0] wr_ptr;
    logic [CW-1:0]     n_cnt;
    logic [FSW-1:0]    step_cnt;
    logic [LUT_AW-1:0] focal_idx;

    logic signed [INPUT_WD-1:0] dline [DEPTH];
    logic [DLY_WD-1:0]          lut   [LUT_DEPTH];

    logic [DLY_WD-1:0]     cur_dly;
    logic signed [WW-1:0]  wt_sel;

    logic                  s1_valid;
    logic [DLY_WD-1:0]     s1_rd_ptr;
    logic                  s1_zero;
    logic signed [WW-1:0]  s1_wt;

    logic                       s2_valid;
    logic signed [INPUT_WD-1:0] s2_y;
    logic signed [WW-1:0]       s2_wt;

    logic                       s3_valid;
    logic signed [PW-1:0]       s3_p;
    logic signed [INPUT_WD-1:0] s3_y;

    logic signed [PW-1:0]     y_ext;
    logic signed [PW-1:0]     w_ext;
    logic signed [PW-1:0]     prod;
    logic signed [RW-1:0]     rnd_q;
    logic signed [OUT_WD-1:0] sat_q;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state (start low always returns to IDLE, even with tx_en high)
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !tx_en) state_nxt = RUN;
            RUN:     if (!start)          state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy      = 1'b0;
        accept    = 1'b0;
        lut_wr_ok = 1'b0;
        case (state)
            IDLE: lut_wr_ok = lut_we;
            RUN: begin
                busy   = 1'b1;
                accept = start && !tx_en;
            end
            default: ;
        endcase
    end

    // Sample bookkeeping is zero throughout IDLE, so every RUN starts from n=0
    always_ff @(posedge clk) begin
        if (rst || !busy) begin
            wr_ptr    <= '0;
            n_cnt     <= '0;
            step_cnt  <= '0;
            focal_idx <= '0;
        end else if (accept) begin
            wr_ptr <= wr_ptr + DLY_WD'(1);
            if (n_cnt != N_SAT) begin
                n_cnt <= n_cnt + CW'(1);
            end
            if (step_cnt == STEP_LAST) begin
                step_cnt <= '0;
                if (focal_idx != FOCAL_LAST) begin
                    focal_idx <= focal_idx + LUT_AW'(1);
                end
            end else begin
                step_cnt <= step_cnt + FSW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            dline[wr_ptr] <= ch_in;
        end
        if (lut_wr_ok) begin
            lut[lut_addr] <= lut_din;
        end
    end

    always_comb begin
        cur_dly = lut[focal_idx];
        wt_sel  = apo_bypass ? UNITY : WW'(apo_din);
    end

    // Stage 1 registers the read address; the delay-line write lands on the same
    // edge, so a zero delay reads the current sample one cycle later.
    // Samples older than the RUN start are forced to zero via the count compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_rd_ptr <= '0;
            s1_zero   <= 1'b0;
            s1_wt     <= '0;
        end else begin
            s1_valid  <= accept;
            s1_rd_ptr <= wr_ptr - cur_dly;
            s1_zero   <= (n_cnt < {1'b0, cur_dly});
            s1_wt     <= wt_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_y     <= '0;
            s2_wt    <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_y     <= s1_zero ? '0 : dline[s1_rd_ptr];
            s2_wt    <= s1_wt;
        end
    end

    always_comb begin
        y_ext = PW'(s2_y);
        w_ext = PW'(s2_wt);
        prod  = y_ext * w_ext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid <= 1'b0;
            s3_p     <= '0;
            s3_y     <= '0;
        end else begin
            s3_valid <= s2_valid;
            s3_p     <= prod;
            s3_y     <= s2_y;
        end
    end

    always_comb begin
        rnd_q = RW'((s3_p + RND) >>> (APO_WD - 1));
    end

    generate
        if (OUT_WD >= RW) begin : g_extend
            always_comb begin
                sat_q = OUT_WD'(rnd_q);
            end
        end else begin : g_saturate
            localparam logic signed [RW-1:0] SAT_MAX = {{(RW - OUT_WD + 1){1'b0}}, {(OUT_WD - 1){1'b1}}};
            localparam logic signed [RW-1:0] SAT_MIN = {{(RW - OUT_WD + 1){1'b1}}, {(OUT_WD - 1){1'b0}}};
            always_comb begin
                if (rnd_q > SAT_MAX) begin
                    sat_q = {1'b0, {(OUT_WD - 1){1'b1}}};
                end else if (rnd_q < SAT_MIN) begin
                    sat_q = {1'b1, {(OUT_WD - 1){1'b0}}};
                end else begin
                    sat_q = OUT_WD'(rnd_q);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            cd_dout    <= '0;
        end else begin
            dout_valid <= s3_valid;
            dout       <= s3_valid ? sat_q : '0;
            if (s3_valid) begin
                cd_dout <= s3_y;
            end
        end
    end

endmodule

// File: tb/tb_dbf_chan_param.sv
// Directed bench for dbf_chan_param: table of weighting vectors plus ramp sequences
// for delay gating, focal-zone stepping, tx pauses, pointer wrap and reset.
module tb_dbf_chan_param;

    localparam int INPUT_WD   = 14;
    localparam int APO_WD     = 16;
    localparam int OUT_WD     = 32;
    localparam int DLY_WD     = 8;
    localparam int LUT_AW     = 10;
    localparam int FOCAL_STEP = 4;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic                       tx_en = 1'b0;
    logic                       start = 1'b0;
    logic signed [INPUT_WD-1:0] ch_in = '0;
    logic signed [APO_WD-1:0]   apo_din = '0;
    logic                       apo_bypass = 1'b0;
    logic [LUT_AW-1:0]          lut_addr = '0;
    logic [DLY_WD-1:0]          lut_din = '0;
    logic                       lut_we = 1'b0;
    logic signed [OUT_WD-1:0]   dout;
    logic                       dout_valid;
    logic signed [INPUT_WD-1:0] cd_dout;
    logic                       busy;

    always #5 clk = ~clk;

    dbf_chan_param #(
        .INPUT_WD  (INPUT_WD),
        .APO_WD    (APO_WD),
        .OUT_WD    (OUT_WD),
        .DLY_WD    (DLY_WD),
        .LUT_AW    (LUT_AW),
        .FOCAL_STEP(FOCAL_STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_en     (tx_en),
        .start     (start),
        .ch_in     (ch_in),
        .apo_din   (apo_din),
        .apo_bypass(apo_bypass),
        .lut_addr  (lut_addr),
        .lut_din   (lut_din),
        .lut_we    (lut_we),
        .dout      (dout),
        .dout_valid(dout_valid),
        .cd_dout   (cd_dout),
        .busy      (busy)
    );

    typedef struct {
        bit v;
        int d;
        int y;
    } exp_t;

    typedef struct {
        int ch;
        int apo;
        bit byp;
        int exp_d;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   lut_m  [1024];
    int   x_hist [4096];
    int   n_m    = 0;
    bit   run_m  = 1'b0;
    int   last_y = 0;
    exp_t pipe   [3];
    vec_t tab    [10];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the reference model, check the results due now
    task automatic cycle(input bit st, input bit tx, input int ch, input int apo, input bit byp,
                         input bit use_tab = 1'b0, input int tab_d = 0);
        exp_t   e;
        bit     acc;
        int     f, d, a, y;
        longint p, r;
        start      = st;
        tx_en      = tx;
        ch_in      = ch[INPUT_WD-1:0];
        apo_din    = apo[APO_WD-1:0];
        apo_bypass = byp;
        acc = run_m && st && !tx;
        e.v = acc;
        e.d = 0;
        e.y = 0;
        if (acc) begin
            f = n_m / FOCAL_STEP;
            if (f > 1023) f = 1023;
            d = lut_m[f];
            x_hist[n_m] = ch;
            y = (n_m < d) ? 0 : x_hist[n_m - d];
            a = byp ? 32768 : apo;
            p = longint'(y) * longint'(a);
            r = (p + 16384) >>> 15;
            if (r > 64'sd2147483647)  r = 64'sd2147483647;
            if (r < -64'sd2147483648) r = -64'sd2147483648;
            e.d = use_tab ? tab_d : int'(r);
            e.y = y;
            n_m++;
        end
        if (lut_we && !run_m) lut_m[lut_addr] = int'(lut_din);
        if (run_m) begin
            if (!st) begin
                run_m = 1'b0;
                n_m   = 0;
            end
        end else if (st && !tx) begin
            run_m = 1'b1;
        end
        @(posedge clk);
        #1;
        if (pipe[2].v) last_y = pipe[2].y;
        chk("dout_valid", dout_valid, pipe[2].v);
        chk("dout", dout, pipe[2].v ? pipe[2].d : 0);
        chk("cd_dout", cd_dout, last_y);
        chk("busy", busy, run_m);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = e;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        start  = 1'b0;
        tx_en  = 1'b0;
        lut_we = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        run_m  = 1'b0;
        n_m    = 0;
        last_y = 0;
        for (int i = 0; i < 3; i++) pipe[i] = '{v: 1'b0, d: 0, y: 0};
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_cd_dout", cd_dout, 0);
        chk("rst_busy", busy, 0);
    endtask

    task automatic lut_wr(input int addr, input int val);
        lut_addr = addr[LUT_AW-1:0];
        lut_din  = val[DLY_WD-1:0];
        lut_we   = 1'b1;
        cycle(1'b0, 1'b0, 0, 0, 1'b0);
        lut_we   = 1'b0;
    endtask

    task automatic lut_fill(input int val);
        for (int i = 0; i < 128; i++) lut_wr(i, val);
    endtask

    task automatic idle(input int ncyc);
        for (int i = 0; i < ncyc; i++) cycle(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) pipe[i] = '{v: 1'b0, d: 0, y: 0};
        for (int i = 0; i < 1024; i++) lut_m[i] = 0;

        tab[0] = '{ch: 3,     apo: 16384,  byp: 1'b0, exp_d: 2};
        tab[1] = '{ch: -3,    apo: 16384,  byp: 1'b0, exp_d: -1};
        tab[2] = '{ch: 100,   apo: 0,      byp: 1'b1, exp_d: 100};
        tab[3] = '{ch: -8192, apo: 0,      byp: 1'b1, exp_d: -8192};
        tab[4] = '{ch: 8191,  apo: 32767,  byp: 1'b0, exp_d: 8191};
        tab[5] = '{ch: -8192, apo: -32768, byp: 1'b0, exp_d: 8192};
        tab[6] = '{ch: 5,     apo: -16384, byp: 1'b0, exp_d: -2};
        tab[7] = '{ch: 1,     apo: 16384,  byp: 1'b0, exp_d: 1};
        tab[8] = '{ch: -1,    apo: 16384,  byp: 1'b0, exp_d: 0};
        tab[9] = '{ch: 7,     apo: 0,      byp: 1'b0, exp_d: 0};

        do_reset();
        idle(2);

        // Zero delay, unity weight: ramp passes straight through
        lut_fill(0);
        cycle(1'b1, 1'b0, 0, 0, 1'b1);
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, i, 0, 1'b1);
        idle(5);

        // Weighting and rounding vectors, zero delay
        cycle(1'b1, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 1'b0, tab[i].ch, tab[i].apo, tab[i].byp, 1'b1, tab[i].exp_d);
        idle(5);

        // Focal zones: LUT[0]=5 gates the first zone to zero, then LUT[1]=2, LUT[2]=0
        lut_wr(0, 5);
        lut_wr(1, 2);
        cycle(1'b1, 1'b0, 0, 0, 1'b0);
        for (int i = 1; i <= 12; i++) cycle(1'b1, 1'b0, i, 0, 1'b1);
        idle(5);

        // tx_en pause mid-RUN, then start=0 with tx_en=1 returns to IDLE
        cycle(1'b1, 1'b0, 0, 0, 1'b0);
        for (int i = 1; i <= 5; i++)  cycle(1'b1, 1'b0, i, 0, 1'b1);
        for (int i = 0; i < 3; i++)   cycle(1'b1, 1'b1, 99, 0, 1'b1);
        for (int i = 6; i <= 10; i++) cycle(1'b1, 1'b0, i, 0, 1'b1);
        cycle(1'b0, 1'b1, 50, 0, 1'b1);
        cycle(1'b1, 1'b1, 51, 0, 1'b1);
        idle(5);

        // Maximum delay across the pointer wrap; LUT write during RUN must be ignored
        lut_fill(255);
        cycle(1'b1, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            if (i == 100) begin
                lut_addr = 10'd25;
                lut_din  = 8'd0;
                lut_we   = 1'b1;
            end
            cycle(1'b1, 1'b0, i + 1, 0, 1'b1);
            lut_we = 1'b0;
        end
        idle(5);

        // Reset with results in flight: nothing emerges afterwards
        lut_fill(0);
        cycle(1'b1, 1'b0, 0, 0, 1'b0);
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 10 * i, 0, 1'b1);
        do_reset();
        idle(6);

        // After reset, stale history must read as zero
        lut_wr(0, 3);
        cycle(1'b1, 1'b0, 0, 0, 1'b0);
        for (int i = 1; i <= 6; i++) cycle(1'b1, 1'b0, i, 0, 1'b1);
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dbf_chan_param.md
DBF_CHAN_PARAM -- requirements
Module: dbf_chan_param

Interface
REQ-001 SHALL have parameters: INPUT_WD, 14, input sample width; APO_WD, 16, apodisation weight width, Q1.(APO_WD-1); OUT_WD, 32, output width; DLY_WD, 8, delay width, delay-line depth 2^DLY_WD; LUT_AW, 10, delay-LUT address width; FOCAL_STEP, 4, accepted samples per focal zone.
REQ-002 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-003 rst  in  1  one clock; reset is synchronous and active-high.
REQ-004 tx_en  in  1  transmit active; sample acceptance inhibited while high.
REQ-005 start  in  1  receive window enable.
REQ-006 ch_in  in  INPUT_WD  signed channel sample.
REQ-007 apo_din  in  APO_WD  signed apodisation weight, sampled with ch_in.
REQ-008 apo_bypass  in  1  weight forced to unity when high.
REQ-009 lut_addr  in  LUT_AW; lut_din  in  DLY_WD; lut_we  in  1: delay-LUT write port.
REQ-010 dout  out  OUT_WD  signed delayed, weighted sample; dout_valid  out  1.
REQ-011 cd_dout  out  INPUT_WD  delayed sample before weighting (debug); busy  out  1  high in RUN.

Function
REQ-012 FSM states IDLE, RUN; IDLE->RUN when start=1 and tx_en=0; RUN->IDLE when start=0.
REQ-013 Accept = RUN and start=1 and tx_en=0; no sample accepted in IDLE or on the cycle of IDLE->RUN.
REQ-014 tx_en=1 in RUN: pause; no write, no pointer/counter advance, dout_valid=0 for corresponding slots; state held.
REQ-015 Accepted sample n (0-based from RUN entry) written to circular delay line at wr_ptr=n mod 2^DLY_WD; wr_ptr wraps silently.
REQ-016 Focal index f(n)=min(floor(n/FOCAL_STEP), 2^LUT_AW-1); saturates, never wraps.
REQ-017 Delay d(n)=LUT[f(n)]; delayed sample y(n)=x[n-d(n)], where x[k]=0 for k<0; d=0 returns current sample (write-first).
REQ-018 Weight a(n)=apo_din at accept cycle, or 2^(APO_WD-1) (unity) when apo_bypass=1 at that cycle.
REQ-019 p = y*a full precision (INPUT_WD+APO_WD bits); r = (p + 2^(APO_WD-2)) >>> (APO_WD-1), round half up.
REQ-020 dout = r saturated to signed OUT_WD range; sign-extended when OUT_WD exceeds r width.
REQ-021 Latency: dout/dout_valid/cd_dout for sample n appear exactly 3 cycles after its accept cycle; one result per accept, order preserved, fully pipelined (throughput 1/cycle).
REQ-022 dout_valid=0 and dout=0 when no result due; cd_dout holds last delayed sample.
REQ-023 LUT writes honoured only in IDLE; lut_we in RUN ignored, no corruption.
REQ-024 RUN->IDLE: wr_ptr, sample count, focal index cleared; results already in pipeline still emerge; delay-line contents treated as zero on next RUN (per REQ-017).
REQ-025 start=0 and tx_en=1 same cycle: start wins, transition to IDLE.

Reset
REQ-026 rst=1: state IDLE, pointers/counters/pipeline cleared, dout=0, dout_valid=0, cd_dout=0, busy=0 on next edge.
REQ-027 rst mid-RUN: in-flight results discarded, no dout_valid after rst asserted.
REQ-028 Delay-line and LUT contents not reset; sample-count gating (REQ-017) guarantees zero history.

Verification
REQ-029 LUT all 0, bypass=1, ramp ch_in=1,2,3.. -> dout=1,2,3.. 3 cycles after each accept, dout_valid continuous.
REQ-030 LUT[0]=5, FOCAL_STEP=4, ramp from 1 -> dout 0,0,0,0 (n=0..3), then LUT[1] applied from n=4.
REQ-031 apo_din=0x4000 (0.5), ch_in=3 -> dout=2 (1.5 rounded up); ch_in=-3 -> dout=-1.
REQ-032 tx_en pulsed 3 cycles mid-RUN -> 3-cycle gap in dout_valid, no sample lost, pointers resume.
REQ-033 d=255, 300 samples -> correct wrap across wr_ptr 255->0; lut_we in RUN has no effect.
REQ-034 rst asserted with 2 results in flight -> no dout_valid afterwards, all outputs 0.
